// File: rtl/debounce_pulso_botones.sv
// Push-button front end: two-flop sync, per-button debounce, one-cycle press pulse
// and auto-repeat on the four direction buttons (boton_elige never repeats).
module debounce_pulso_botones #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REP_W           = 24
) (
  input  logic       _clk_,
  input  logic       _reset_,
  input  logic       boton_arriba_in,
  input  logic       boton_abajo_in,
  input  logic       boton_izq_in,
  input  logic       boton_der_in,
  input  logic       boton_elige_in,
  output logic       boton_arriba_out,
  output logic       boton_abajo_out,
  output logic       boton_izq_out,
  output logic       boton_der_out,
  output logic       boton_elige_out,
  output logic [4:0] botones_estado
);

  // state    | meaning
  // ESTABLE  | synced input equals debounced level, counter idle
  // CONTANDO | synced input differs, counting persistence cycles
  // REPOSO   | no press pending (released, or elige held)
  // ESPERA   | pressed, waiting REPEAT_DELAY for the first repeat
  // REPITE   | held, one pulse every REPEAT_PERIOD
  typedef enum logic {ESTABLE, CONTANDO} deb_state_t;
  typedef enum logic [1:0] {REPOSO, ESPERA, REPITE} rep_state_t;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [4:0] raw;
  logic [4:0] pulse;
  logic [4:0] level_all;

  assign raw = {boton_elige_in, boton_der_in, boton_izq_in, boton_abajo_in, boton_arriba_in};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    localparam bit CAN_REPEAT = (REPEAT_EN != 0) && (i != 4);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic             out_q;
    deb_state_t       deb_state;
    logic [CNT_W-1:0] deb_cnt;
    rep_state_t       rep_state;
    logic [REP_W-1:0] rep_cnt;

    always_ff @(posedge _clk_ or negedge _reset_) begin
      if (!_reset_) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
      end
    end

    always_ff @(posedge _clk_ or negedge _reset_) begin
      if (!_reset_) begin
        deb_state <= ESTABLE;
        deb_cnt   <= '0;
        level     <= 1'b0;
      end else begin
        case (deb_state)
          ESTABLE: begin
            deb_cnt <= '0;
            if (sync2 != level) deb_state <= CONTANDO;
          end
          CONTANDO: begin
            if (sync2 == level) begin
              deb_cnt   <= '0;
              deb_state <= ESTABLE;
            end else if (deb_cnt == DEB_LAST) begin
              level     <= ~level;
              deb_cnt   <= '0;
              deb_state <= ESTABLE;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          default: begin
            deb_cnt   <= '0;
            deb_state <= ESTABLE;
          end
        endcase
      end
    end

    // A released level wins over any repeat that falls due in the same cycle.
    always_ff @(posedge _clk_ or negedge _reset_) begin
      if (!_reset_) begin
        rep_state <= REPOSO;
        rep_cnt   <= '0;
        level_d   <= 1'b0;
        out_q     <= 1'b0;
      end else begin
        level_d <= level;
        out_q   <= 1'b0;
        if (!level) begin
          rep_state <= REPOSO;
          rep_cnt   <= '0;
        end else begin
          case (rep_state)
            REPOSO: begin
              rep_cnt <= '0;
              if (!level_d) begin
                out_q <= 1'b1;
                if (CAN_REPEAT) rep_state <= ESPERA;
              end
            end
            ESPERA: begin
              if (rep_cnt == DELAY_LAST) begin
                out_q     <= 1'b1;
                rep_cnt   <= '0;
                rep_state <= REPITE;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
            REPITE: begin
              if (rep_cnt == PERIOD_LAST) begin
                out_q   <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
            default: begin
              rep_state <= REPOSO;
              rep_cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign pulse[i]     = out_q;
    assign level_all[i] = level;
  end

  assign boton_arriba_out = pulse[0];
  assign boton_abajo_out  = pulse[1];
  assign boton_izq_out    = pulse[2];
  assign boton_der_out    = pulse[3];
  assign boton_elige_out  = pulse[4];
  assign botones_estado   = level_all;

endmodule

// File: tb/tb_debounce_pulso_botones.sv
// Bench for debounce_pulso_botones: table-driven first press, hand-written corner
// sequences and a randomized run, all against a persistence/repeat-schedule model.
module tb_debounce_pulso_botones;
  localparam int DEB    = 4;
  localparam int DELAY  = 20;
  localparam int PERIOD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;  // {elige, der, izq, abajo, arriba}
  wire        o_arr, o_aba, o_izq, o_der, o_eli;
  wire  [4:0] estado;
  wire  [4:0] outs = {o_eli, o_der, o_izq, o_aba, o_arr};

  int total = 0;
  int bad = 0;
  int ecount = 0;

  // reference model: run length of disagreeing samples, repeat schedule from press edge
  int run[5];
  bit lvl[5];
  bit lvl_p[5];
  bit r1[5];
  bit r2[5];
  int press[5];
  int pq[5][$];

  always #5 clk = ~clk;

  debounce_pulso_botones #(
    .DEBOUNCE_CYCLES(DEB), .CNT_W(3), .REPEAT_EN(1),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .REP_W(5)
  ) dut (
    ._clk_(clk), ._reset_(rst_n),
    .boton_arriba_in(btn[0]), .boton_abajo_in(btn[1]), .boton_izq_in(btn[2]),
    .boton_der_in(btn[3]), .boton_elige_in(btn[4]),
    .boton_arriba_out(o_arr), .boton_abajo_out(o_aba), .boton_izq_out(o_izq),
    .boton_der_out(o_der), .boton_elige_out(o_eli),
    .botones_estado(estado)
  );

  typedef struct {
    logic [4:0] in_btn;
    logic [4:0] exp_out;
    logic [4:0] exp_est;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, ecount, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 5; b++) begin
      run[b] = 0; lvl[b] = 0; lvl_p[b] = 0; r1[b] = 0; r2[b] = 0; press[b] = -1;
      pq[b].delete();
    end
  endtask

  task automatic tick();
    logic [4:0] eo;
    logic [4:0] es;
    @(posedge clk);
    eo = '0;
    es = '0;
    for (int b = 0; b < 5; b++) begin
      bit smp;
      smp = r2[b];
      if (lvl[b] && !lvl_p[b]) begin
        eo[b] = 1'b1;
        press[b] = ecount;
      end else if (lvl[b] && b != 4 && press[b] >= 0 && ecount - press[b] >= DELAY &&
                   (ecount - press[b] - DELAY) % PERIOD == 0) begin
        eo[b] = 1'b1;
      end
      if (!lvl[b]) press[b] = -1;
      lvl_p[b] = lvl[b];
      if (smp != lvl[b]) begin
        run[b]++;
        if (run[b] == DEB + 1) begin
          lvl[b] = !lvl[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
      r2[b] = r1[b];
      r1[b] = btn[b];
      es[b] = lvl[b];
    end
    #1;
    check("model", {outs, estado}, {eo, es});
    for (int b = 0; b < 5; b++) if (outs[b]) pq[b].push_back(ecount);
    ecount++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_now", {outs, estado}, 10'b0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", {outs, estado}, 10'b0);
    rst_n = 1'b1;
    ecount = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_list(input string name, input int b, input int exp[$]);
    check_int({name, "_count"}, pq[b].size(), exp.size());
    for (int k = 0; k < exp.size() && k < pq[b].size(); k++)
      check_int({name, "_edge"}, pq[b][k], exp[k]);
  endtask

  initial begin
    int rem[5];
    for (int i = 0; i < 14; i++) begin
      vecs[i].in_btn  = 5'b00001;
      vecs[i].exp_out = (i == 7) ? 5'b00001 : 5'b00000;
      vecs[i].exp_est = (i >= 6) ? 5'b00001 : 5'b00000;
    end
    vecs[12].in_btn = 5'b00000;
    vecs[13].in_btn = 5'b00000;

    model_clear();
    #2;
    do_reset();

    // first press: pulse at edge 7, level from edge 6
    for (int i = 0; i < 14; i++) begin
      btn = vecs[i].in_btn;
      tick();
      check("table", {outs, estado}, {vecs[i].exp_out, vecs[i].exp_est});
    end
    btn = '0;
    ticks(15);

    // short der bursts never qualify
    do_reset();
    for (int k = 0; k < 4; k++) begin
      btn[3] = (k % 2 == 0);
      ticks(3);
    end
    btn = '0;
    ticks(12);
    check_int("der_glitch_pulses", pq[3].size(), 0);
    check_int("der_glitch_level", int'(estado[3]), 0);

    // held abajo auto-repeats, release stops it
    do_reset();
    btn[1] = 1'b1;
    ticks(60);
    btn = '0;
    ticks(20);
    check_list("abajo_repeat", 1, '{7, 27, 35, 43, 51, 59});

    // elige never repeats; re-press gives exactly one new pulse
    do_reset();
    btn[4] = 1'b1;
    ticks(60);
    check_list("elige_hold", 4, '{7});
    btn = '0;
    ticks(15);
    btn[4] = 1'b1;
    ticks(25);
    check_list("elige_repress", 4, '{7, 82});
    btn = '0;
    ticks(12);

    // simultaneous arriba + izq
    do_reset();
    btn = 5'b00101;
    ticks(12);
    check_list("both_arriba", 0, '{7});
    check_list("both_izq", 2, '{7});
    btn = '0;
    ticks(12);

    // reset while arriba repeats, then restart from scratch
    do_reset();
    btn[0] = 1'b1;
    ticks(36);
    check_int("pre_reset_pulse", int'(o_arr), 1);
    #1;
    do_reset();
    ticks(40);
    check_list("after_reset", 0, '{7, 27, 35});
    btn = '0;
    ticks(12);

    // randomized hold/glitch patterns on all five buttons
    do_reset();
    for (int b = 0; b < 5; b++) rem[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++) begin
        if (rem[b] == 0) begin
          btn[b] = 1'($urandom_range(0, 1));
          rem[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                               : int'($urandom_range(5, 60));
        end
        rem[b]--;
      end
      if (c == 2000) begin
        #1;
        do_reset();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
